keypad_code_entry: RTL and testbench
====================================

// Module: keypad_code_entry
// PURPOSE
//  Upstream feeder of the access-control FSM. Debounces raw keypad presses, accumulates decimal digits,
//  and on ENTER presents a 4-bit access_code with a one-cycle validate_code pulse.
//  Handles CLEAR, inter-key timeout and out-of-range entries. Sits between the keypad scanner and the door FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    cycles key_press/key_code must be stable before a press (or release) is accepted
//  ENTRY_TIMEOUT    1000  idle cycles inside an entry before the partial entry is discarded
//  MAX_DIGITS       2     maximum decimal digits accepted per entry
//  LOCKOUT_CYCLES   4096  lockout length (only with KEYPAD_LOCKOUT_EN)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  synchronous active-high reset
//  key_press      in   1  raw keypad "key down" level, asynchronous to entry logic, may bounce
//  key_code       in   4  raw key id: 0-9 digits, 4'hA CLEAR, 4'hB ENTER, 4'hC-4'hF ignored
//  access_code    out  4  last submitted code; held until next submission
//  validate_code  out  1  one-cycle pulse: access_code valid
//  entry_error    out  1  one-cycle pulse: ENTER with value >15, no digits, or digit overflow
//  entry_active   out  1  high while digits are being collected
//  locked         out  1  lockout active (tied 0 without KEYPAD_LOCKOUT_EN)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, digit count 0, accumulator 0, debouncer disarmed-low.
//  - Debounce: stability counter restarts whenever key_press or key_code changes.
//    On reaching DEBOUNCE_CYCLES with key_press=1 and armed: emit key_evt (1 cycle) carrying key_code, then disarm.
//    Re-arm only after key_press=0 stable for DEBOUNCE_CYCLES. Holding a key yields exactly one event.
//  - FSM states:
//    IDLE   : digit evt -> acc=digit, cnt=1, ENTRY. ENTER -> entry_error. CLEAR/ignored -> stay.
//    ENTRY  : digit evt, cnt<MAX_DIGITS -> acc=acc*10+digit, cnt++.
//             digit evt, cnt==MAX_DIGITS -> entry_error, discard, IDLE.
//             CLEAR -> discard, IDLE (no pulse).
//             ENTER -> SUBMIT.
//             timer==ENTRY_TIMEOUT-1 with no evt -> discard, IDLE (no pulse).
//    SUBMIT : acc<=15 -> access_code<=acc[3:0], validate_code=1.
//             acc>15 -> entry_error=1, access_code unchanged.
//             Always next IDLE (exactly one cycle).
//  - Latency: validate_code asserts 2 cycles after the ENTER key_evt cycle (evt->SUBMIT registered, SUBMIT->pulse registered).
//  - access_code is registered and stable from the validate_code cycle until the next validate_code, so the
//    downstream check one cycle later sees the right value.
//  - Widths: acc is 7 bits (max 99); multiply by 10 done as (acc<<3)+(acc<<1), no truncation.
//  - entry_active = (state==ENTRY). Timeout counter clears on every key_evt and outside ENTRY; saturates, no wrap.
//  - A key_evt coincident with timeout expiry: the key event wins.
//  - Reset mid-entry/mid-debounce: everything returns to reset values next cycle; a key still held must be
//    released and re-pressed.
// CONFIGURATION
//  KEYPAD_LOCKOUT_EN defined:
//    - 3 consecutive entry_error pulses (any validate_code clears the counter) -> locked=1 for LOCKOUT_CYCLES.
//    - While locked, key events are dropped, the FSM is forced to IDLE, and no validate_code/entry_error is issued.
//    - On expiry: locked=0, error count 0.
//  KEYPAD_LOCKOUT_EN undefined:
//    - No lockout logic; locked is driven constant 0.
// STRUCTURE
//  - Package keypad_pkg: state enum (IDLE/ENTRY/SUBMIT), key constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB,
//    MAX_CODE=15, LOCKOUT_ERR_LIMIT=3.
//  - Sub-module key_debounce (clk, rst, key_press, key_code -> key_evt, key_val), parameterised by DEBOUNCE_CYCLES.
//  - Top holds the FSM, accumulator, timeout counter and optional lockout.
// TESTING (DEBOUNCE_CYCLES=4, ENTRY_TIMEOUT=20, LOCKOUT_CYCLES=50)
//  1. Clean presses "1","2",ENTER -> access_code=4'd12, validate_code high exactly one cycle, 2 cycles after ENTER evt.
//  2. key_press toggles every 2 cycles for 10 cycles, then holds "7" for 30 cycles -> exactly one key_evt;
//     then ENTER -> access_code=7.
//  3. "4","2",ENTER -> entry_error pulse; access_code keeps its previous value; no validate_code.
//     "1","2","3" -> entry_error on the third digit.
//  4. "5", then 25 idle cycles -> entry_active drops after 20; a following ENTER -> entry_error (no digits).
//  5. "9",CLEAR,"3",ENTER -> access_code=3. Reset asserted mid-entry after "1" -> all outputs 0, entry_active=0.
//  6. KEYPAD_LOCKOUT_EN: three bad ENTERs -> locked=1 for 50 cycles, keys ignored; after expiry "4",ENTER -> validate_code.

Source files
------------

// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//   Shared types and constants for the keypad code-entry block.
//   - state_t          : entry FSM states (IDLE / ENTRY / SUBMIT)
//   - KEY_CLEAR/ENTER  : special key ids on the keypad scanner bus
//   - MAX_CODE         : largest value accepted as an access code
//   - LOCKOUT_ERR_LIMIT: consecutive errors that trigger a lockout
//                        (only meaningful with KEYPAD_LOCKOUT_EN)
//   - ACC_W            : decimal accumulator width (holds up to 99)
// ---------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        SUBMIT = 2'd2
    } state_t;

    localparam logic [3:0]  KEY_CLEAR         = 4'hA;
    localparam logic [3:0]  KEY_ENTER         = 4'hB;
    localparam int unsigned MAX_CODE          = 15;
    localparam int unsigned LOCKOUT_ERR_LIMIT = 3;
    localparam int          ACC_W             = 7;

    function automatic logic is_digit(input logic [3:0] k);
        return (k <= 4'd9);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
//   Synchronises the raw keypad lines into the clk domain and turns a stable
//   key press into a single one-cycle event. A press is accepted only after
//   key_press/key_code have been unchanged for DEBOUNCE_CYCLES cycles while
//   armed; the debouncer then disarms and re-arms only after key_press=0 has
//   been stable for DEBOUNCE_CYCLES. Holding a key gives exactly one event.
//   Reset leaves it disarmed with a low sampled level, so a key held through
//   reset must be released and pressed again.
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   key_press  in   raw key-down level (asynchronous, may bounce)
//   key_code   in   raw key id
//   key_evt    out  one-cycle accepted-press pulse
//   key_val    out  key id belonging to key_evt
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_press,
    input  logic [3:0] key_code,
    output logic       key_evt,
    output logic [3:0] key_val
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             press_p0, press_p1, press_p2;
    logic [3:0]       code_p0, code_p1, code_p2;
    logic [CNT_W-1:0] stable_cnt;
    logic             armed;
    logic             changed;
    logic             stable;

    // p2 holds the previous synchronised sample; any difference restarts the count
    assign changed = (press_p1 != press_p2) || (code_p1 != code_p2);
    assign stable  = !changed && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            press_p0   <= 1'b0;
            press_p1   <= 1'b0;
            press_p2   <= 1'b0;
            code_p0    <= '0;
            code_p1    <= '0;
            code_p2    <= '0;
            stable_cnt <= '0;
            armed      <= 1'b0;
            key_evt    <= 1'b0;
            key_val    <= '0;
        end else begin
            // stage p0/p1: two-flop synchroniser, stage p2: last-seen sample
            press_p0 <= key_press;
            press_p1 <= press_p0;
            press_p2 <= press_p1;
            code_p0  <= key_code;
            code_p1  <= code_p0;
            code_p2  <= code_p1;
            key_evt  <= 1'b0;

            // Count saturates at DEBOUNCE_CYCLES-1; "stable" stays true while nothing moves
            if (changed) begin
                stable_cnt <= '0;
            end else if (!stable) begin
                stable_cnt <= stable_cnt + 1'b1;
            end

            if (stable) begin
                if (press_p2) begin
                    if (armed) begin
                        key_evt <= 1'b1;
                        key_val <= code_p2;
                        armed   <= 1'b0;
                    end
                end else begin
                    armed <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_code_entry.sv
// ---------------------------------------------------------------------------
// keypad_code_entry
//   Front end of the door access controller. Debounces keypad presses,
//   accumulates up to MAX_DIGITS decimal digits and, on ENTER, presents a
//   4-bit access_code with a one-cycle validate_code pulse. CLEAR and an
//   inter-key timeout discard a partial entry silently; ENTER with no digits,
//   a value above 15, or too many digits produce a one-cycle entry_error.
//   validate_code follows the ENTER key event by two cycles.
// Configuration
//   KEYPAD_LOCKOUT_EN : when defined, three consecutive entry_error pulses
//                       lock the keypad for LOCKOUT_CYCLES cycles. Any
//                       validate_code clears the error run. Without the
//                       macro, locked is constant 0.
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   key_press      in   raw key-down level
//   key_code       in   raw key id (0-9 digit, A clear, B enter, C-F ignored)
//   access_code    out  last accepted code, held until the next acceptance
//   validate_code  out  one-cycle pulse, access_code is fresh
//   entry_error    out  one-cycle pulse, rejected entry
//   entry_active   out  high while digits are being collected
//   locked         out  lockout in progress
// ---------------------------------------------------------------------------
module keypad_code_entry
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ENTRY_TIMEOUT   = 1000,
    parameter int MAX_DIGITS      = 2,
    parameter int LOCKOUT_CYCLES  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_press,
    input  logic [3:0] key_code,
    output logic [3:0] access_code,
    output logic       validate_code,
    output logic       entry_error,
    output logic       entry_active,
    output logic       locked
);

    localparam int DIG_W = $clog2(MAX_DIGITS + 1);
    localparam int TMR_W = $clog2(ENTRY_TIMEOUT + 1);

    logic             key_evt;
    logic [3:0]       key_val;
    logic             lock_active;
    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [DIG_W-1:0] dig_cnt;
    logic [TMR_W-1:0] timer;

    // acc*10 + d built from shifts; the operand is at most a single digit here
    function automatic logic [ACC_W-1:0] mul10_add(input logic [ACC_W-1:0] a,
                                                   input logic [3:0]       d);
        return (a << 3) + (a << 1) + ACC_W'(d);
    endfunction

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .key_press(key_press),
        .key_code (key_code),
        .key_evt  (key_evt),
        .key_val  (key_val)
    );

    assign entry_active = (state == ENTRY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            acc           <= '0;
            dig_cnt       <= '0;
            timer         <= '0;
            access_code   <= '0;
            validate_code <= 1'b0;
            entry_error   <= 1'b0;
        end else begin
            validate_code <= 1'b0;
            entry_error   <= 1'b0;

            if (lock_active) begin
                // Key events are dropped and any entry is abandoned while locked
                state   <= IDLE;
                acc     <= '0;
                dig_cnt <= '0;
                timer   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (key_evt) begin
                            if (is_digit(key_val)) begin
                                acc     <= ACC_W'(key_val);
                                dig_cnt <= DIG_W'(1);
                                state   <= ENTRY;
                            end else if (key_val == KEY_ENTER) begin
                                entry_error <= 1'b1;
                            end
                        end
                    end

                    ENTRY: begin
                        // A key event takes priority over a coincident timeout
                        if (key_evt) begin
                            timer <= '0;
                            if (is_digit(key_val)) begin
                                if (dig_cnt < DIG_W'(MAX_DIGITS)) begin
                                    acc     <= mul10_add(acc, key_val);
                                    dig_cnt <= dig_cnt + 1'b1;
                                end else begin
                                    entry_error <= 1'b1;
                                    acc         <= '0;
                                    dig_cnt     <= '0;
                                    state       <= IDLE;
                                end
                            end else if (key_val == KEY_CLEAR) begin
                                acc     <= '0;
                                dig_cnt <= '0;
                                state   <= IDLE;
                            end else if (key_val == KEY_ENTER) begin
                                state <= SUBMIT;
                            end
                        end else if (timer == TMR_W'(ENTRY_TIMEOUT - 1)) begin
                            acc     <= '0;
                            dig_cnt <= '0;
                            timer   <= '0;
                            state   <= IDLE;
                        end else begin
                            timer <= sat_inc(timer);
                        end
                    end

                    SUBMIT: begin
                        if (acc <= ACC_W'(MAX_CODE)) begin
                            access_code   <= acc[3:0];
                            validate_code <= 1'b1;
                        end else begin
                            entry_error <= 1'b1;
                        end
                        acc     <= '0;
                        dig_cnt <= '0;
                        timer   <= '0;
                        state   <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef KEYPAD_LOCKOUT_EN
    localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [1:0]      err_cnt;
    logic [LK_W-1:0] lock_timer;

    // Watches the registered pulses, so locking starts the cycle after the third error
    always_ff @(posedge clk) begin
        if (rst) begin
            locked     <= 1'b0;
            err_cnt    <= '0;
            lock_timer <= '0;
        end else if (locked) begin
            if (lock_timer == LK_W'(LOCKOUT_CYCLES - 1)) begin
                locked     <= 1'b0;
                err_cnt    <= '0;
                lock_timer <= '0;
            end else begin
                lock_timer <= lock_timer + 1'b1;
            end
        end else if (validate_code) begin
            err_cnt <= '0;
        end else if (entry_error) begin
            if (err_cnt == 2'(LOCKOUT_ERR_LIMIT - 1)) begin
                locked     <= 1'b1;
                lock_timer <= '0;
                err_cnt    <= '0;
            end else begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign lock_active = locked;
`else
    assign locked      = 1'b0;
    assign lock_active = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_code_entry.sv
// ---------------------------------------------------------------------------
// tb_keypad_code_entry
//   Scoreboard bench. Each key press is fed to a digit-list reference model
//   that pushes the expected outcome (error or accepted code, plus latency
//   from the key event) into a queue; a negedge monitor pops and compares on
//   every validate_code / entry_error pulse and checks access_code holds
//   between pulses. Directed scenarios are followed by random key sequences.
// ---------------------------------------------------------------------------
module tb_keypad_code_entry;

    localparam int DEB  = 4;
    localparam int TMO  = 20;
    localparam int MAXD = 2;
    localparam int LCK  = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_press = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic [3:0] access_code;
    logic       validate_code;
    logic       entry_error;
    logic       entry_active;
    logic       locked;

    keypad_code_entry #(
        .DEBOUNCE_CYCLES(DEB),
        .ENTRY_TIMEOUT  (TMO),
        .MAX_DIGITS     (MAXD),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_press    (key_press),
        .key_code     (key_code),
        .access_code  (access_code),
        .validate_code(validate_code),
        .entry_error  (entry_error),
        .entry_active (entry_active),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit         is_err;
        logic [3:0] code;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         m_digits[$];
    logic [3:0] m_code = 4'd0;
    int         m_errs = 0;
    bit         m_lock_pending = 0;
    int         n_evt_exp = 0;

    function automatic void push_exp(input bit e, input int lat);
        exp_t x;
        x.is_err = e;
        x.code   = m_code;
        x.lat    = lat;
        sb.push_back(x);
        if (e) begin
            m_errs++;
            if (m_errs == 3) begin
`ifdef KEYPAD_LOCKOUT_EN
                m_lock_pending = 1;
`endif
                m_errs = 0;
            end
        end else begin
            m_errs = 0;
        end
    endfunction

    function automatic void model_key(input logic [3:0] k);
        int v;
        if (k <= 4'd9) begin
            if (m_digits.size() == MAXD) begin
                push_exp(1, 1);
                m_digits.delete();
            end else begin
                m_digits.push_back(int'(k));
            end
        end else if (k == 4'hA) begin
            m_digits.delete();
        end else if (k == 4'hB) begin
            if (m_digits.size() == 0) begin
                push_exp(1, 1);
            end else begin
                v = 0;
                foreach (m_digits[i]) v = v * 10 + m_digits[i];
                if (v <= 15) begin
                    m_code = 4'(v);
                    push_exp(0, 2);
                end else begin
                    push_exp(1, 2);
                end
                m_digits.delete();
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic raw_press(input logic [3:0] k, input int hold, input int rel);
        key_code  = k;
        key_press = 1'b1;
        step(hold);
        key_press = 1'b0;
        step(rel);
        n_evt_exp++;
    endtask

    task automatic handle_lock();
`ifdef KEYPAD_LOCKOUT_EN
        int n;
        if (m_lock_pending) begin
            m_lock_pending = 0;
            check("locked_set", int'(locked), 1);
            raw_press(4'd5, 10, 8);
            check("locked_no_entry", int'(entry_active), 0);
            n = 0;
            while (locked && n < LCK + 20) begin
                step(1);
                n++;
            end
            check("locked_expired", int'(locked), 0);
            step(2);
        end
`endif
    endtask

    task automatic press_key(input logic [3:0] k);
        model_key(k);
        raw_press(k, 10, 8);
        handle_lock();
    endtask

    task automatic bounce_press(input logic [3:0] k, input int hold_after, input int rel);
        model_key(k);
        key_code = k;
        for (int i = 0; i < 5; i++) begin
            key_press = (i % 2 == 0);
            step(2);
        end
        key_press = 1'b1;
        step(hold_after);
        key_press = 1'b0;
        step(rel);
        n_evt_exp++;
        handle_lock();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_digits.delete();
        m_code = 4'd0;
        m_errs = 0;
        m_lock_pending = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_access_code"},   int'(access_code),   0);
        check({tag, "_validate_code"}, int'(validate_code), 0);
        check({tag, "_entry_error"},   int'(entry_error),   0);
        check({tag, "_entry_active"},  int'(entry_active),  0);
        check({tag, "_locked"},        int'(locked),        0);
    endtask

    // ---------------- monitor ----------------
    bit         rst_seen = 0;
    bit         prev_pulse = 0;
    logic [3:0] hold_code = 4'd0;
    int         last_evt_cyc = -100;
    int         n_evt_seen = 0;
    int         lk_run = 0;
    exp_t       mon_e;

    always @(negedge clk) begin
        if (rst) begin
            rst_seen   = 1;
            prev_pulse = 0;
            lk_run     = 0;
        end else begin
            if (rst_seen) begin
                hold_code = 4'd0;
                rst_seen  = 0;
            end
            if (validate_code || entry_error) begin
                check("pulse_exclusive", int'(validate_code && entry_error), 0);
                check("pulse_width", int'(prev_pulse), 0);
                if (sb.size() == 0) begin
                    check("pulse_without_expectation", sb.size(), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("pulse_is_error", int'(entry_error), int'(mon_e.is_err));
                    check("pulse_access_code", int'(access_code), int'(mon_e.code));
                    check("pulse_latency", cyc - last_evt_cyc, mon_e.lat);
                    hold_code = mon_e.code;
                end
            end else begin
                check("access_code_hold", int'(access_code), int'(hold_code));
            end
            prev_pulse = validate_code || entry_error;
            if (dut.u_debounce.key_evt) begin
                last_evt_cyc = cyc;
                n_evt_seen++;
            end
`ifdef KEYPAD_LOCKOUT_EN
            if (locked) begin
                lk_run++;
            end else if (lk_run > 0) begin
                check("lock_length", lk_run, LCK);
                lk_run = 0;
            end
`else
            check("locked_tied_low", int'(locked), 0);
`endif
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int r;
        logic [3:0] k;

        step(3);
        rst = 1'b0;
        check_reset_outputs("reset");
        step(8);

        // clean "1","2",ENTER -> 12
        press_key(4'd1);
        check("entry_active_after_digit", int'(entry_active), 1);
        press_key(4'd2);
        press_key(4'hB);
        check("code_is_12", int'(access_code), 12);

        // bouncing ENTER held long in IDLE -> exactly one error
        bounce_press(4'hB, 30, 8);
        // bouncing "7" then ENTER -> 7
        bounce_press(4'd7, 8, 8);
        press_key(4'hB);
        check("code_is_7", int'(access_code), 7);

        // "4","2",ENTER -> out of range, code unchanged
        press_key(4'd4);
        press_key(4'd2);
        press_key(4'hB);
        check("code_kept_7", int'(access_code), 7);
        // third digit overflows
        press_key(4'd1);
        press_key(4'd2);
        press_key(4'd3);
        check("overflow_back_idle", int'(entry_active), 0);

        // "5" then idle past the timeout, ENTER -> no digits
        press_key(4'd5);
        check("timeout_still_active", int'(entry_active), 1);
        step(15);
        m_digits.delete();
        check("timeout_dropped", int'(entry_active), 0);
        press_key(4'hB);

        // "9",CLEAR,"3",ENTER -> 3
        press_key(4'd9);
        press_key(4'hA);
        check("clear_idle", int'(entry_active), 0);
        press_key(4'd3);
        press_key(4'hB);
        check("code_is_3", int'(access_code), 3);

        // reset mid-entry
        press_key(4'd1);
        pulse_reset();
        check_reset_outputs("midreset");
        check("midreset_queue_empty", sb.size(), 0);
        step(10);

        // key held across reset produces no new digit
        key_code  = 4'd8;
        key_press = 1'b1;
        step(10);
        n_evt_exp++;
        check("held_digit_active", int'(entry_active), 1);
        pulse_reset();
        check("held_reset_inactive", int'(entry_active), 0);
        step(15);
        key_press = 1'b0;
        step(8);
        check("held_no_new_event", int'(entry_active), 0);
        press_key(4'hB);

        // three bad ENTERs, then a good code
        press_key(4'hB);
        press_key(4'hB);
        press_key(4'hB);
        press_key(4'd4);
        press_key(4'hB);
        check("code_is_4", int'(access_code), 4);

        // random key sequences, occasionally idling past the timeout
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      k = 4'($urandom_range(0, 9));
            else if (r < 75) k = 4'hB;
            else if (r < 85) k = 4'hA;
            else             k = 4'($urandom_range(12, 15));
            press_key(k);
            if ($urandom_range(0, 5) == 0) begin
                step(15);
                m_digits.delete();
            end
        end

        step(20);
        check("scoreboard_drained", sb.size(), 0);
        check("key_event_count", n_evt_seen, n_evt_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
